spi_slave_regs: RTL and testbench
=================================

// Module: spi_slave_regs
// PURPOSE
//  SPI responder for the team's 2-byte SPI frame: a 64 x 8 register file accessed over SPI.
//  Frame: address byte {rw, 0, addr[5:0]}, then one data byte. Both bytes are MSB first.
//  SPI mode 3: SCLK idles high. The initiator drives MOSI on the falling edge and samples MISO on the rising edge.
//  Sits on the sensor side; local logic reads/writes the same registers through a parallel port.
// PARAMETERS
//  SYNC_STAGES  2      flip-flop stages on spi_clk/spi_cs/spi_mosi (legal values: 2 or 3)
//  RO_MASK      64'h0  bit i=1: address i is read-only from SPI (SPI writes dropped, local writes still allowed)
//  RST_VAL      8'h00  reset value of every register
// PORTS
//  clk           in   1  system clock; all logic is on its rising edge
//  rst_n         in   1  synchronous reset, active-low
//  spi_clk       in   1  SPI clock from initiator (asynchronous to clk)
//  spi_cs        in   1  chip select, active-low
//  spi_mosi      in   1  serial data from initiator
//  spi_miso      out  1  serial data to initiator
//  spi_miso_oe   out  1  1 = drive spi_miso; top level tristates the pin when 0
//  loc_addr      in   6  local register address
//  loc_we        in   1  local write strobe
//  loc_wdata     in   8  local write data
//  loc_rdata     out  8  combinational read of regs[loc_addr]
//  wr_valid      out  1  one-cycle pulse: an SPI write has been committed
//  wr_addr       out  6  address of the committed write; valid while wr_valid=1
//  wr_data       out  8  data of the committed write; valid while wr_valid=1
//  frame_err     out  1  one-cycle pulse: frame aborted or reserved bit set
// BEHAVIOUR
//  Reset values: all regs=RST_VAL; spi_miso=0; spi_miso_oe=0; wr_valid=0; frame_err=0; state=WAIT_CS.
//  Synchronisation and edges
//   - All SPI inputs pass through SYNC_STAGES flip-flops.
//   - rise/fall of spi_clk and spi_cs are detected on the synchronised signals.
//   - Requirement: each spi_clk phase lasts >= 4 clk periods.
//  State machine
//   IDLE: cs falls -> ADDR, bit_cnt=0, spi_miso_oe=1, spi_miso=0.
//   ADDR: sample spi_mosi on each sclk rise into shift[7:0].
//     - At the 8th rise: latch rw=shift[7] and addr=shift[5:0].
//     - If shift[6]=1: pulse frame_err and go to WAIT_CS.
//     - Otherwise go to DATA. If rw=1, load tx_sr=regs[addr] on the following clk.
//   DATA: on each sclk fall, spi_miso=tx_sr[7] and tx_sr shifts left (drive only when rw=1, else miso=0).
//     - On each sclk rise, sample mosi.
//     - At the 8th rise: if rw=0 and RO_MASK[addr]=0, write regs[addr]. Then go to WAIT_CS.
//   WAIT_CS: sclk edges are ignored and spi_miso=0. cs rise -> IDLE with spi_miso_oe=0.
//  Write commit
//   - The register write happens, and wr_valid pulses, in the clk cycle after the 16th rise is detected.
//   - wr_valid does not pulse for RO addresses or for read frames.
//  Boundaries
//   - cs rises in ADDR or DATA (short frame): no write, frame_err pulses once, go to IDLE.
//   - More than 16 sclk rises while cs is low: extra bits ignored, miso stays 0.
//   - SPI commit and loc_we to the same address in the same cycle: the SPI value wins.
//   - Read snapshot: regs[addr] is captured at the address-byte boundary. A later local write does not alter bits already in flight.
//   - cs low at reset release, or reset asserted mid-frame: go to WAIT_CS.
//     - No write happens and no frame_err pulses.
//     - A new frame starts only after cs goes high, then low.
//   - sclk edges while cs is high: ignored.
// STRUCTURE
//  - spi_defs.vh (shared with the SPI initiator):
//    - frame field positions: RW_BIT=7, RSVD_BIT=6, ADDR_W=6, DATA_W=8, FRAME_BITS=16
//    - state encodings IDLE/ADDR/DATA/WAIT_CS
//  - Sub-module spi_sync_edge: SYNC_STAGES synchroniser plus rise/fall pulse outputs.
//    Instantiated for spi_clk and spi_cs; spi_mosi uses the synchroniser path only.
//  - Register file is a flat array with one write port (SPI/local mux) and two read paths.
// TESTING
//  Drive the bench with the existing SPI initiator (clk_generator divider >= 4).
//  1. Write 0xA5 to address 0x12 (frame 0x12,0xA5) -> regs[0x12]=0xA5; wr_valid pulses once with addr 0x12, data 0xA5.
//  2. Local write 0x3C to address 0x05, then SPI read frame 0x85 -> initiator read_data=0x3C; no wr_valid pulse.
//  3. RO_MASK bit 0x20 set, SPI write 0xFF to address 0x20 -> regs[0x20] unchanged; no wr_valid.
//  4. Raise cs after 11 bits of a write to address 0x01 -> no write; frame_err pulses once; next full frame succeeds.
//  5. Address byte 0x4A (reserved bit set) -> frame_err pulses; no write; miso reads 0x00.
//  6. Assert rst_n=0 mid-DATA, release with cs still low -> no write; following frames are ignored until cs goes high; then a normal frame works.

Source files
------------

// File: rtl/spi_slave_regs_pkg.sv
// Frame layout and responder states shared by the SPI register-file slice.
package spi_slave_regs_pkg;

   localparam int RW_BIT     = 7;
   localparam int RSVD_BIT   = 6;
   localparam int ADDR_W     = 6;
   localparam int DATA_W     = 8;
   localparam int FRAME_BITS = 16;
   localparam int NUM_REGS   = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ADDR    = 2'd1,
      DATA    = 2'd2,
      WAIT_CS = 2'd3
   } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous input with rise/fall pulses
// derived from the synchronised level.
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_LEVEL   = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         chain <= {SYNC_STAGES{RST_LEVEL}};
         prev  <= RST_LEVEL;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], din};
         prev  <= chain[SYNC_STAGES-1];
      end
   end

   assign sync = chain[SYNC_STAGES-1];
   assign rise = sync & ~prev;
   assign fall = ~sync & prev;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-3 responder giving an initiator access to a 64 x 8 register file
// that local logic shares through a parallel port.
module spi_slave_regs
   import spi_slave_regs_pkg::*;
#(
   parameter int          SYNC_STAGES = 2,
   parameter logic [63:0] RO_MASK     = 64'h0,
   parameter logic [7:0]  RST_VAL     = 8'h00
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_clk,
   input  logic              spi_cs,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   input  logic [ADDR_W-1:0] loc_addr,
   input  logic              loc_we,
   input  logic [DATA_W-1:0] loc_wdata,
   output logic [DATA_W-1:0] loc_rdata,
   output logic              wr_valid,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              frame_err
);

   logic sclk_sync, sclk_rise, sclk_fall;
   logic cs_sync, cs_rise, cs_fall;
   logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_LEVEL(1'b1)) u_sclk_sync (
      .clk(clk), .rst_n(rst_n), .din(spi_clk),
      .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
   );

   // cs resets to the asserted level so a chip select held low through reset
   // never looks like the start of a new frame.
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_LEVEL(1'b0)) u_cs_sync (
      .clk(clk), .rst_n(rst_n), .din(spi_cs),
      .sync(cs_sync), .rise(cs_rise), .fall(cs_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_LEVEL(1'b0)) u_mosi_sync (
      .clk(clk), .rst_n(rst_n), .din(spi_mosi),
      .sync(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
   );

   spi_state_t        state, state_d;
   logic [3:0]        bit_cnt, bit_cnt_d;
   logic [7:0]        shift, shift_d;
   logic [7:0]        tx_sr, tx_sr_d;
   logic              rw, rw_d;
   logic [ADDR_W-1:0] addr, addr_d;
   logic              load, load_d;
   logic              miso_d, oe_d, err_d, commit_d;
   logic [ADDR_W-1:0] wr_addr_d;
   logic [DATA_W-1:0] wr_data_d;
   logic [DATA_W-1:0] regs [NUM_REGS];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= WAIT_CS;
         bit_cnt     <= '0;
         shift       <= '0;
         tx_sr       <= '0;
         rw          <= 1'b0;
         addr        <= '0;
         load        <= 1'b0;
         spi_miso    <= 1'b0;
         spi_miso_oe <= 1'b0;
         frame_err   <= 1'b0;
         wr_valid    <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
      end else begin
         state       <= state_d;
         bit_cnt     <= bit_cnt_d;
         shift       <= shift_d;
         tx_sr       <= tx_sr_d;
         rw          <= rw_d;
         addr        <= addr_d;
         load        <= load_d;
         spi_miso    <= miso_d;
         spi_miso_oe <= oe_d;
         frame_err   <= err_d;
         wr_valid    <= commit_d;
         wr_addr     <= wr_addr_d;
         wr_data     <= wr_data_d;
      end
   end

   always_comb begin
      state_d   = state;
      bit_cnt_d = bit_cnt;
      shift_d   = shift;
      tx_sr_d   = tx_sr;
      rw_d      = rw;
      addr_d    = addr;
      load_d    = 1'b0;
      miso_d    = spi_miso;
      oe_d      = spi_miso_oe;
      err_d     = 1'b0;
      commit_d  = 1'b0;
      wr_addr_d = wr_addr;
      wr_data_d = wr_data;
      case (state)
         IDLE: begin
            if (cs_fall) begin
               state_d   = ADDR;
               bit_cnt_d = '0;
               oe_d      = 1'b1;
               miso_d    = 1'b0;
            end
         end
         ADDR: begin
            if (cs_rise) begin
               err_d   = 1'b1;
               state_d = IDLE;
               oe_d    = 1'b0;
               miso_d  = 1'b0;
            end else if (sclk_rise) begin
               shift_d   = {shift[6:0], mosi_sync};
               bit_cnt_d = bit_cnt + 4'd1;
               if (bit_cnt == 4'd7) begin
                  rw_d   = shift_d[RW_BIT];
                  addr_d = shift_d[ADDR_W-1:0];
                  if (shift_d[RSVD_BIT]) begin
                     err_d   = 1'b1;
                     state_d = WAIT_CS;
                  end else begin
                     state_d = DATA;
                     load_d  = shift_d[RW_BIT];
                  end
               end
            end
         end
         DATA: begin
            // Snapshot taken one cycle after the address byte; later local
            // writes cannot disturb bits already being shifted out.
            if (load) tx_sr_d = regs[addr];
            if (cs_rise) begin
               err_d   = 1'b1;
               state_d = IDLE;
               oe_d    = 1'b0;
               miso_d  = 1'b0;
            end else if (sclk_fall) begin
               miso_d  = rw ? tx_sr[7] : 1'b0;
               tx_sr_d = {tx_sr[6:0], 1'b0};
            end else if (sclk_rise) begin
               shift_d   = {shift[6:0], mosi_sync};
               bit_cnt_d = bit_cnt + 4'd1;
               if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                  state_d = WAIT_CS;
                  if (!rw && !RO_MASK[addr]) begin
                     commit_d  = 1'b1;
                     wr_addr_d = addr;
                     wr_data_d = shift_d;
                  end
               end
            end
         end
         WAIT_CS: begin
            miso_d = 1'b0;
            if (cs_sync) begin
               state_d = IDLE;
               oe_d    = 1'b0;
            end
         end
         default: state_d = WAIT_CS;
      endcase
   end

   // Single write port: a committed SPI write takes priority over loc_we.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
      end else if (wr_valid) begin
         regs[wr_addr] <= wr_data;
      end else if (loc_we) begin
         regs[loc_addr] <= loc_wdata;
      end
   end

   assign loc_rdata = regs[loc_addr];

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed self-checking bench for spi_slave_regs driven by a mode-3 SPI initiator model.
module tb_spi_slave_regs;

   localparam int HALF = 80;
   localparam logic [63:0] RO = 64'h0000_0001_0000_0000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       spi_clk = 1'b1;
   logic       spi_cs = 1'b1;
   logic       spi_mosi = 1'b0;
   logic       spi_miso;
   logic       spi_miso_oe;
   logic [5:0] loc_addr = '0;
   logic       loc_we = 1'b0;
   logic [7:0] loc_wdata = '0;
   logic [7:0] loc_rdata;
   logic       wr_valid;
   logic [5:0] wr_addr;
   logic [7:0] wr_data;
   logic       frame_err;

   int errors = 0;
   int checks = 0;
   int wr_cnt = 0;
   int err_cnt = 0;
   logic [5:0] last_wr_addr = '0;
   logic [7:0] last_wr_data = '0;

   spi_slave_regs #(.SYNC_STAGES(2), .RO_MASK(RO), .RST_VAL(8'h00)) dut (
      .clk(clk), .rst_n(rst_n),
      .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .loc_addr(loc_addr), .loc_we(loc_we), .loc_wdata(loc_wdata), .loc_rdata(loc_rdata),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_valid) begin
         wr_cnt++;
         last_wr_addr = wr_addr;
         last_wr_data = wr_data;
      end
      if (frame_err) err_cnt++;
   end

   task automatic spi_bits(input logic [15:0] val, input int n, output logic [15:0] rd);
      rd = '0;
      for (int i = 0; i < n; i++) begin
         spi_clk  = 1'b0;
         spi_mosi = val[15-i];
         #HALF;
         spi_clk = 1'b1;
         rd = {rd[14:0], spi_miso};
         #HALF;
      end
   endtask

   task automatic spi_frame(input logic [7:0] a, input logic [7:0] d, input int n, output logic [15:0] rd);
      spi_cs = 1'b0;
      #HALF;
      spi_bits({a, d}, n, rd);
      spi_cs = 1'b1;
      #(4*HALF);
   endtask

   task automatic loc_write(input logic [5:0] a, input logic [7:0] d);
      @(negedge clk);
      loc_addr  = a;
      loc_wdata = d;
      loc_we    = 1'b1;
      @(negedge clk);
      loc_we = 1'b0;
   endtask

   task automatic loc_read(input logic [5:0] a, output logic [7:0] d);
      @(negedge clk);
      loc_addr = a;
      #1;
      d = loc_rdata;
   endtask

   task automatic test_reset();
      logic [7:0] v;
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (spi_miso !== 1'b0) begin errors++; $display("[TB] FAIL reset_miso: got %b expected 0", spi_miso); end
      checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_oe: got %b expected 0", spi_miso_oe); end
      checks++; if (wr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_valid: got %b expected 0", wr_valid); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      loc_read(6'h00, v);
      checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL reset_reg00: got %h expected 00", v); end
      loc_read(6'h3F, v);
      checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL reset_reg3f: got %h expected 00", v); end
   endtask

   task automatic test_write();
      int w0, e0;
      logic [15:0] rd;
      logic [7:0] v;
      w0 = wr_cnt; e0 = err_cnt;
      spi_frame(8'h12, 8'hA5, 16, rd);
      checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("[TB] FAIL write_pulses: got %0d expected 1", wr_cnt - w0); end
      checks++; if (last_wr_addr !== 6'h12) begin errors++; $display("[TB] FAIL write_addr: got %h expected 12", last_wr_addr); end
      checks++; if (last_wr_data !== 8'hA5) begin errors++; $display("[TB] FAIL write_data: got %h expected a5", last_wr_data); end
      checks++; if (err_cnt - e0 !== 0) begin errors++; $display("[TB] FAIL write_err: got %0d expected 0", err_cnt - e0); end
      checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("[TB] FAIL write_oe_after: got %b expected 0", spi_miso_oe); end
      loc_read(6'h12, v);
      checks++; if (v !== 8'hA5) begin errors++; $display("[TB] FAIL write_reg12: got %h expected a5", v); end
   endtask

   task automatic test_read();
      int w0;
      logic [15:0] rd;
      loc_write(6'h05, 8'h3C);
      w0 = wr_cnt;
      spi_frame(8'h85, 8'h00, 16, rd);
      checks++; if (rd[7:0] !== 8'h3C) begin errors++; $display("[TB] FAIL read_data: got %h expected 3c", rd[7:0]); end
      checks++; if (rd[15:8] !== 8'h00) begin errors++; $display("[TB] FAIL read_addr_phase_miso: got %h expected 00", rd[15:8]); end
      checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("[TB] FAIL read_no_wr: got %0d expected 0", wr_cnt - w0); end
   endtask

   task automatic test_read_only();
      int w0;
      logic [15:0] rd;
      logic [7:0] v;
      w0 = wr_cnt;
      spi_frame(8'h20, 8'hFF, 16, rd);
      checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("[TB] FAIL ro_no_wr: got %0d expected 0", wr_cnt - w0); end
      loc_read(6'h20, v);
      checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL ro_reg20: got %h expected 00", v); end
   endtask

   task automatic test_short_frame();
      int w0, e0;
      logic [15:0] rd;
      logic [7:0] v;
      w0 = wr_cnt; e0 = err_cnt;
      spi_frame(8'h01, 8'h77, 11, rd);
      checks++; if (err_cnt - e0 !== 1) begin errors++; $display("[TB] FAIL short_err: got %0d expected 1", err_cnt - e0); end
      checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("[TB] FAIL short_no_wr: got %0d expected 0", wr_cnt - w0); end
      loc_read(6'h01, v);
      checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL short_reg01: got %h expected 00", v); end
      w0 = wr_cnt; e0 = err_cnt;
      spi_frame(8'h01, 8'h5A, 16, rd);
      loc_read(6'h01, v);
      checks++; if (v !== 8'h5A) begin errors++; $display("[TB] FAIL short_next_reg01: got %h expected 5a", v); end
      checks++; if (wr_cnt - w0 !== 1 || err_cnt - e0 !== 0) begin
         errors++; $display("[TB] FAIL short_next_pulses: got wr=%0d err=%0d expected wr=1 err=0", wr_cnt - w0, err_cnt - e0);
      end
   endtask

   task automatic test_reserved();
      int w0, e0;
      logic [15:0] rd;
      logic [7:0] v;
      loc_write(6'h0A, 8'h11);
      w0 = wr_cnt; e0 = err_cnt;
      spi_frame(8'h4A, 8'h99, 16, rd);
      checks++; if (err_cnt - e0 !== 1) begin errors++; $display("[TB] FAIL rsvd_err: got %0d expected 1", err_cnt - e0); end
      checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("[TB] FAIL rsvd_no_wr: got %0d expected 0", wr_cnt - w0); end
      checks++; if (rd[7:0] !== 8'h00) begin errors++; $display("[TB] FAIL rsvd_miso: got %h expected 00", rd[7:0]); end
      loc_read(6'h0A, v);
      checks++; if (v !== 8'h11) begin errors++; $display("[TB] FAIL rsvd_reg0a: got %h expected 11", v); end
      e0 = err_cnt;
      spi_frame(8'hCA, 8'h00, 16, rd);
      checks++; if (rd !== 16'h0000 || err_cnt - e0 !== 1) begin
         errors++; $display("[TB] FAIL rsvd_read: got miso=%h err=%0d expected miso=0000 err=1", rd, err_cnt - e0);
      end
   endtask

   task automatic test_collision();
      logic [15:0] rd;
      logic [7:0] v;
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      loc_addr = 6'h07; loc_wdata = 8'h22; loc_we = 1'b1;
      fork
         spi_frame(8'h07, 8'hE1, 16, rd);
         begin
            for (int n = 0; n < 20000 && !seen; n++) begin
               @(negedge clk);
               if (wr_valid) seen = 1'b1;
            end
            @(posedge clk);
            #1 loc_we = 1'b0;
         end
      join
      checks++; if (!seen) begin errors++; $display("[TB] FAIL collide_wr_valid: got none expected pulse within bound"); end
      loc_read(6'h07, v);
      checks++; if (v !== 8'hE1) begin errors++; $display("[TB] FAIL collide_reg07: got %h expected e1", v); end
   endtask

   task automatic test_reset_mid_frame();
      int w0, e0;
      logic [15:0] rd;
      logic [7:0] v;
      spi_cs = 1'b0;
      #HALF;
      spi_bits({8'h03, 8'hC3}, 12, rd);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      w0 = wr_cnt; e0 = err_cnt;
      spi_bits({8'h03, 8'hC3}, 4, rd);
      spi_bits({8'h04, 8'h44}, 16, rd);
      checks++; if (rd !== 16'h0000) begin errors++; $display("[TB] FAIL rstmid_miso: got %h expected 0000", rd); end
      spi_cs = 1'b1;
      #(4*HALF);
      checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("[TB] FAIL rstmid_no_wr: got %0d expected 0", wr_cnt - w0); end
      checks++; if (err_cnt - e0 !== 0) begin errors++; $display("[TB] FAIL rstmid_no_err: got %0d expected 0", err_cnt - e0); end
      loc_read(6'h03, v);
      checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_reg03: got %h expected 00", v); end
      loc_read(6'h04, v);
      checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_reg04: got %h expected 00", v); end
      w0 = wr_cnt;
      spi_frame(8'h03, 8'hC3, 16, rd);
      loc_read(6'h03, v);
      checks++; if (v !== 8'hC3) begin errors++; $display("[TB] FAIL rstmid_after_reg03: got %h expected c3", v); end
      checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("[TB] FAIL rstmid_after_pulse: got %0d expected 1", wr_cnt - w0); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_read_only();
      test_short_frame();
      test_reserved();
      test_collision();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
